axi_multicore_ctrl: RTL and testbench
=====================================

AXI_MULTICORE_CTRL -- requirements
Module: axi_multicore_ctrl

Interface
REQ-001 Parameters (name, default, meaning):
- REG_WIDTH, 32, register width.
- MEM_WIDTH, 64, instruction memory word width.
- MEM_ADDR_WIDTH, 9, memory address width.
- N_CORES, 4, number of coprocessor cores; 3*N_CORES+1 <= REG_WIDTH.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- cmd_register, in, REG_WIDTH, command code (level-held by software).
- core_sel_register, in, REG_WIDTH, target core index.
- address_register, in, REG_WIDTH, host memory address (low MEM_ADDR_WIDTH bits used).
- data_in_register, in, MEM_WIDTH, host write data.
- start_cc_pointer_register / end_cc_pointer_register, in, REG_WIDTH each, broadcast to all cores.
- status_register, out, REG_WIDTH, packed per-core state plus busy flag.
- data_o_register, out, MEM_WIDTH, read-back data.
- mem_r_addr / mem_r_valid / mem_r_data, out/out/in, MEM_ADDR_WIDTH/1/MEM_WIDTH, shared 1-cycle-latency BRAM read port.
- mem_w_addr / mem_w_data / mem_w_valid, out, MEM_ADDR_WIDTH/MEM_WIDTH/1, BRAM write port.
- cop_rst, out, 1, core reset.
- cop_valid / cop_ready, out/in, N_CORES each, per-core start handshake.
- cop_done / cop_accept / cop_error, in, N_CORES each, per-core result.
- cop_mem_addr, in, N_CORES*MEM_ADDR_WIDTH, per-core fetch address (core i at [i*MEM_ADDR_WIDTH+:MEM_ADDR_WIDTH]).
- cop_mem_valid / cop_mem_ready, in/out, N_CORES each, per-core fetch request/grant.
- cop_mem_data_valid, out, N_CORES, one-hot; mem_r_data is valid for that core this cycle.
- cop_mem_data, out, MEM_WIDTH, equal to mem_r_data, broadcast.
- cop_start_cc_pointer / cop_end_cc_pointer, out, REG_WIDTH each, copies of the pointer registers.

Function
REQ-003 Command codes: NOP=0, WRITE=1, READ=2, START=3, RESET=4, RESTART=5, READ_ELAPSED_CLOCK=6; other codes behave as NOP.
REQ-004 Per-core state codes: IDLE=0, RUNNING=1, ACCEPTED=2, REJECTED=3, ERROR=4.
REQ-005 status_register[3i+:3] = state of core i; status_register[REG_WIDTH-1] = 1 while any core is RUNNING; all other bits 0.
REQ-006 rst_master = rst OR (cmd_register==RESET); cop_rst = rst_master; rst_master applies the reset values of REQ-016 on the next clk edge.
REQ-007 A core_sel_register value >= N_CORES makes START, RESTART and READ_ELAPSED_CLOCK no-ops, with data_o_register = 0.
REQ-008 WRITE with no core RUNNING: mem_w_valid=1, mem_w_addr=address low bits, mem_w_data=data_in_register, asserted every cycle the command is held. With any core RUNNING, the write is suppressed.
REQ-009 READ with no core RUNNING: mem_r_valid=1, mem_r_addr=address low bits, data_o_register=mem_r_data (combinational). Valid from the second held cycle onward. With any core RUNNING, data_o_register=0 and no read is issued.
REQ-010 START, selected core IDLE: cop_valid[sel]=1 while held. On a cycle with cop_ready[sel]=1, the core goes RUNNING at the next edge and its elapsed counter clears to 0. A selected core that is not IDLE is ignored. Other cores are unaffected, so cores run concurrently.
REQ-011 RUNNING core i, evaluated each cycle: if cop_error[i], next state is ERROR (error wins over a simultaneous done). Else if cop_done[i], next state is ACCEPTED when cop_accept[i]=1, otherwise REJECTED.
REQ-012 RESTART: a selected core in ACCEPTED, REJECTED or ERROR goes to IDLE next edge; a selected core in IDLE or RUNNING is ignored.
REQ-013 Per-core REG_WIDTH elapsed counter: increments by 1 each cycle while RUNNING, saturates at all-ones, and holds in other states. READ_ELAPSED_CLOCK returns the selected core's counter, zero-extended, on data_o_register.
REQ-014 Fetch arbitration:
- Eligible core: cop_mem_valid[i]=1 and (RUNNING, or IDLE with cop_valid[i]=1).
- Round-robin grant starts the search at pointer rr.
- Grant is combinational: cop_mem_ready[g]=1 (one-hot), mem_r_addr=core g address, mem_r_valid=1.
- rr becomes g+1 mod N_CORES after a grant; rr is unchanged when nothing is eligible.
- cop_mem_ready is all-zero when nothing is eligible.
REQ-015 cop_mem_data_valid is the one-hot grant delayed by exactly one cycle; it is 0 on the cycle after a no-grant cycle.

Reset
REQ-016 Reset values:
- All core states IDLE; status_register=0.
- All elapsed counters 0; rr=0; cop_mem_data_valid=0.
- cop_valid, cop_mem_ready, mem_w_valid and mem_r_valid are 0 during the reset cycle.
REQ-017 A reset while any core is RUNNING aborts all cores: the cores see cop_rst, and no result is recorded.

Verification
REQ-018 Write 0xA5 at address 3, then READ address 3 with no core running -> data_o_register=0xA5 on the second READ cycle.
REQ-019 START core 1, cop_ready[1] pulsed; cop_done[1]=cop_accept[1]=1 after 10 cycles -> status[5:3]=2; READ_ELAPSED_CLOCK with sel=1 returns 10; RESTART sets status[5:3]=0.
REQ-020 Cores 0 and 2 RUNNING, both cop_mem_valid held high for 4 cycles -> grants alternate 0,2,0,2; cop_mem_data_valid follows each grant by 1 cycle.
REQ-021 Core 3 RUNNING: cop_error[3] and cop_done[3] asserted in the same cycle -> status[11:9]=4. A WRITE issued during the run produces no mem_w_valid.
REQ-022 Core 0 RUNNING, cmd=RESET for 1 cycle -> status_register=0, counters 0, cop_rst high for that cycle.
REQ-023 core_sel=5 with N_CORES=4 and START held -> cop_valid=0, state unchanged.

Source files
------------

// File: rtl/axi_multicore_ctrl.sv
// Host-command front end for a bank of coprocessor cores: per-core lifecycle FSMs,
// elapsed-cycle counters, host BRAM access and round-robin sharing of the BRAM read port.
module axi_multicore_ctrl #(
  parameter int REG_WIDTH      = 32,
  parameter int MEM_WIDTH      = 64,
  parameter int MEM_ADDR_WIDTH = 9,
  parameter int N_CORES        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REG_WIDTH-1:0]              cmd_register,
  input  logic [REG_WIDTH-1:0]              core_sel_register,
  input  logic [REG_WIDTH-1:0]              address_register,
  input  logic [MEM_WIDTH-1:0]              data_in_register,
  input  logic [REG_WIDTH-1:0]              start_cc_pointer_register,
  input  logic [REG_WIDTH-1:0]              end_cc_pointer_register,
  output logic [REG_WIDTH-1:0]              status_register,
  output logic [MEM_WIDTH-1:0]              data_o_register,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_r_addr,
  output logic                              mem_r_valid,
  input  logic [MEM_WIDTH-1:0]              mem_r_data,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_w_addr,
  output logic [MEM_WIDTH-1:0]              mem_w_data,
  output logic                              mem_w_valid,
  output logic                              cop_rst,
  output logic [N_CORES-1:0]                cop_valid,
  input  logic [N_CORES-1:0]                cop_ready,
  input  logic [N_CORES-1:0]                cop_done,
  input  logic [N_CORES-1:0]                cop_accept,
  input  logic [N_CORES-1:0]                cop_error,
  input  logic [N_CORES*MEM_ADDR_WIDTH-1:0] cop_mem_addr,
  input  logic [N_CORES-1:0]                cop_mem_valid,
  output logic [N_CORES-1:0]                cop_mem_ready,
  output logic [N_CORES-1:0]                cop_mem_data_valid,
  output logic [MEM_WIDTH-1:0]              cop_mem_data,
  output logic [REG_WIDTH-1:0]              cop_start_cc_pointer,
  output logic [REG_WIDTH-1:0]              cop_end_cc_pointer
);

  // Handshakes: a core start fires on a cycle with cop_valid[i] && cop_ready[i];
  // a fetch is granted on the same cycle cop_mem_ready[i] is high, and its data
  // arrives one cycle later flagged by cop_mem_data_valid[i].

  localparam int RR_W = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  localparam logic [REG_WIDTH-1:0] CMD_WRITE   = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CMD_READ    = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] CMD_START   = REG_WIDTH'(3);
  localparam logic [REG_WIDTH-1:0] CMD_RESET   = REG_WIDTH'(4);
  localparam logic [REG_WIDTH-1:0] CMD_RESTART = REG_WIDTH'(5);
  localparam logic [REG_WIDTH-1:0] CMD_ELAPSED = REG_WIDTH'(6);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUNNING  = 3'd1,
    ST_ACCEPTED = 3'd2,
    ST_REJECTED = 3'd3,
    ST_ERROR    = 3'd4
  } core_state_t;

  core_state_t            state_q [N_CORES];
  core_state_t            state_d [N_CORES];
  logic [REG_WIDTH-1:0]   cnt_q   [N_CORES];
  logic [REG_WIDTH-1:0]   cnt_d   [N_CORES];
  logic [RR_W-1:0]        rr_q, rr_d;
  logic [N_CORES-1:0]     dv_q;
  logic [N_CORES-1:0]     sel_hot, running, eligible, grant;
  logic                   rst_master, sel_ok, any_running, granted;
  logic                   unused_addr_bits;

  assign rst_master  = rst || (cmd_register == CMD_RESET);
  assign cop_rst     = rst_master;
  assign sel_ok      = |sel_hot;
  assign any_running = |running;

  assign cop_mem_data         = mem_r_data;
  assign cop_mem_data_valid   = dv_q;
  assign cop_mem_ready        = grant;
  assign cop_start_cc_pointer = start_cc_pointer_register;
  assign cop_end_cc_pointer   = end_cc_pointer_register;
  assign unused_addr_bits     = ^address_register[REG_WIDTH-1:MEM_ADDR_WIDTH];

  always_comb begin
    sel_hot   = '0;
    running   = '0;
    cop_valid = '0;
    eligible  = '0;
    for (int i = 0; i < N_CORES; i++) begin
      sel_hot[i]   = (core_sel_register == REG_WIDTH'(i));
      running[i]   = (state_q[i] == ST_RUNNING);
      cop_valid[i] = !rst_master && (cmd_register == CMD_START) && sel_hot[i] &&
                     (state_q[i] == ST_IDLE);
      eligible[i]  = !rst_master && cop_mem_valid[i] &&
                     (running[i] || cop_valid[i]);
    end
  end

  // Round-robin search beginning at rr_q; the winner's successor becomes the new start.
  always_comb begin
    logic [RR_W:0]   sum;
    logic [RR_W-1:0] idx;
    grant   = '0;
    granted = 1'b0;
    rr_d    = rr_q;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N_CORES; k++) begin
      sum = {1'b0, rr_q} + (RR_W+1)'(k);
      if (sum >= (RR_W+1)'(N_CORES)) sum = sum - (RR_W+1)'(N_CORES);
      idx = sum[RR_W-1:0];
      if (!granted && eligible[idx]) begin
        granted    = 1'b1;
        grant[idx] = 1'b1;
        rr_d       = (idx == RR_W'(N_CORES-1)) ? '0 : idx + RR_W'(1);
      end
    end
  end

  always_comb begin
    mem_r_valid = 1'b0;
    mem_r_addr  = '0;
    if (granted) begin
      mem_r_valid = 1'b1;
      for (int i = 0; i < N_CORES; i++)
        if (grant[i]) mem_r_addr = cop_mem_addr[i*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
    end else if (!rst_master && (cmd_register == CMD_READ) && !any_running) begin
      mem_r_valid = 1'b1;
      mem_r_addr  = address_register[MEM_ADDR_WIDTH-1:0];
    end
  end

  assign mem_w_valid = !rst_master && (cmd_register == CMD_WRITE) && !any_running;
  assign mem_w_addr  = address_register[MEM_ADDR_WIDTH-1:0];
  assign mem_w_data  = data_in_register;

  always_comb begin
    data_o_register = '0;
    if ((cmd_register == CMD_READ) && !any_running) begin
      data_o_register = mem_r_data;
    end else if ((cmd_register == CMD_ELAPSED) && sel_ok) begin
      for (int i = 0; i < N_CORES; i++)
        if (sel_hot[i]) data_o_register = MEM_WIDTH'(cnt_q[i]);
    end
  end

  always_comb begin
    status_register = '0;
    for (int i = 0; i < N_CORES; i++) status_register[3*i +: 3] = state_q[i];
    status_register[REG_WIDTH-1] = any_running;
  end

  // Per-core lifecycle; error outranks a simultaneous done.
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (cop_valid[i] && cop_ready[i]) begin
            state_d[i] = ST_RUNNING;
            cnt_d[i]   = '0;
          end
        end
        ST_RUNNING: begin
          if (cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + REG_WIDTH'(1);
          if (cop_error[i])      state_d[i] = ST_ERROR;
          else if (cop_done[i])  state_d[i] = cop_accept[i] ? ST_ACCEPTED : ST_REJECTED;
        end
        ST_ACCEPTED, ST_REJECTED, ST_ERROR: begin
          if ((cmd_register == CMD_RESTART) && sel_hot[i]) state_d[i] = ST_IDLE;
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_master) begin
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      rr_q <= '0;
      dv_q <= '0;
    end else begin
      for (int i = 0; i < N_CORES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      rr_q <= rr_d;
      dv_q <= grant;
    end
  end

endmodule

// File: tb/tb_axi_multicore_ctrl.sv
// Directed bench for axi_multicore_ctrl with a behavioural 1-cycle-latency BRAM.
module tb_axi_multicore_ctrl;

  localparam int RW = 32;
  localparam int MW = 64;
  localparam int AW = 9;
  localparam int NC = 4;

  localparam logic [RW-1:0] NOP = 0, WRITE = 1, READ = 2, START = 3,
                            RESET = 4, RESTART = 5, ELAPSED = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] cmd_register, core_sel_register, address_register;
  logic [MW-1:0] data_in_register;
  logic [RW-1:0] start_cc_pointer_register, end_cc_pointer_register;
  logic [RW-1:0] status_register;
  logic [MW-1:0] data_o_register;
  logic [AW-1:0] mem_r_addr, mem_w_addr;
  logic          mem_r_valid, mem_w_valid;
  logic [MW-1:0] mem_r_data, mem_w_data;
  logic          cop_rst;
  logic [NC-1:0] cop_valid, cop_ready, cop_done, cop_accept, cop_error;
  logic [NC*AW-1:0] cop_mem_addr;
  logic [NC-1:0] cop_mem_valid, cop_mem_ready, cop_mem_data_valid;
  logic [MW-1:0] cop_mem_data;
  logic [RW-1:0] cop_start_cc_pointer, cop_end_cc_pointer;

  logic [MW-1:0] mem [512];
  int checks = 0;
  int failures = 0;

  axi_multicore_ctrl #(.REG_WIDTH(RW), .MEM_WIDTH(MW), .MEM_ADDR_WIDTH(AW), .N_CORES(NC)) dut (
    .clk(clk), .rst(rst),
    .cmd_register(cmd_register), .core_sel_register(core_sel_register),
    .address_register(address_register), .data_in_register(data_in_register),
    .start_cc_pointer_register(start_cc_pointer_register),
    .end_cc_pointer_register(end_cc_pointer_register),
    .status_register(status_register), .data_o_register(data_o_register),
    .mem_r_addr(mem_r_addr), .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_valid(mem_w_valid),
    .cop_rst(cop_rst), .cop_valid(cop_valid), .cop_ready(cop_ready),
    .cop_done(cop_done), .cop_accept(cop_accept), .cop_error(cop_error),
    .cop_mem_addr(cop_mem_addr), .cop_mem_valid(cop_mem_valid),
    .cop_mem_ready(cop_mem_ready), .cop_mem_data_valid(cop_mem_data_valid),
    .cop_mem_data(cop_mem_data),
    .cop_start_cc_pointer(cop_start_cc_pointer), .cop_end_cc_pointer(cop_end_cc_pointer)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // behavioural BRAM: write and registered read
  always @(posedge clk) begin
    if (mem_w_valid) mem[mem_w_addr] <= mem_w_data;
    mem_r_data <= mem[mem_r_addr];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after posedge, outputs checked at negedge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic set_cmd(input logic [RW-1:0] c, input logic [RW-1:0] sel);
    cmd_register      = c;
    core_sel_register = sel;
  endtask

  logic [NC-1:0] exp_g  [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
  logic [NC-1:0] exp_dv [4] = '{4'b0000, 4'b0001, 4'b0100, 4'b0001};
  logic [AW-1:0] exp_a  [4] = '{9'd10, 9'd30, 9'd10, 9'd30};
  logic [MW-1:0] exp_d  [4] = '{64'h0, 64'hC0DE00000000000A, 64'hC0DE00000000001E,
                                64'hC0DE00000000000A};

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'hC0DE000000000000 | 64'(i);
    rst = 1'b1;
    set_cmd(WRITE, 0);
    address_register = 3;
    data_in_register = 64'h1;
    start_cc_pointer_register = 32'h1234;
    end_cc_pointer_register   = 32'h5678;
    cop_ready = '0; cop_done = '0; cop_accept = '0; cop_error = '0;
    cop_mem_valid = '0;
    cop_mem_addr = {9'd0, 9'd30, 9'd20, 9'd10};

    // reset cycles: outputs suppressed even with commands present
    mid();
    check_eq("rst_cop_rst", cop_rst, 1);
    check_eq("rst_w_valid", mem_w_valid, 0);
    tick();
    set_cmd(START, 0);
    cop_mem_valid = 4'b0001;
    mid();
    check_eq("rst_cop_valid", cop_valid, 0);
    check_eq("rst_mem_ready", cop_mem_ready, 0);
    check_eq("rst_r_valid", mem_r_valid, 0);
    tick();
    rst = 1'b0;
    set_cmd(NOP, 0);
    cop_mem_valid = '0;
    mid();
    check_eq("rst_status", status_register, 0);
    check_eq("rst_dv", cop_mem_data_valid, 0);
    check_eq("rst_cop_rst_low", cop_rst, 0);
    check_eq("start_ptr", cop_start_cc_pointer, 32'h1234);

    // write 0xA5 at 3, read it back
    tick();
    set_cmd(WRITE, 0);
    address_register = 3;
    data_in_register = 64'hA5;
    mid();
    check_eq("wr_valid", mem_w_valid, 1);
    check_eq("wr_addr", mem_w_addr, 3);
    check_eq("wr_data", mem_w_data, 64'hA5);
    tick();
    set_cmd(READ, 0);
    mid();
    check_eq("rd_valid", mem_r_valid, 1);
    check_eq("rd_addr", mem_r_addr, 3);
    tick();
    mid();
    check_eq("rd_data", data_o_register, 64'hA5);

    // out-of-range core select
    tick();
    set_cmd(START, 5);
    cop_ready = 4'b1111;
    mid();
    check_eq("sel5_valid", cop_valid, 0);
    tick();
    cop_ready = '0;
    set_cmd(ELAPSED, 5);
    mid();
    check_eq("sel5_status", status_register, 0);
    check_eq("sel5_data", data_o_register, 0);

    // core 1: start, run 10 cycles, accept
    tick();
    set_cmd(START, 1);
    mid();
    check_eq("c1_valid", cop_valid, 4'b0010);
    cop_ready = 4'b0010;
    tick();
    cop_ready = '0;
    set_cmd(READ, 1);
    mid();
    check_eq("c1_running", status_register, 32'h80000008);
    check_eq("c1_rd_blocked", data_o_register, 0);
    check_eq("c1_rd_no_valid", mem_r_valid, 0);
    for (int k = 0; k < 9; k++) tick();
    set_cmd(NOP, 1);
    cop_done = 4'b0010;
    cop_accept = 4'b0010;
    tick();
    cop_done = '0;
    cop_accept = '0;
    set_cmd(ELAPSED, 1);
    mid();
    check_eq("c1_accepted", status_register, 32'h00000010);
    check_eq("c1_elapsed", data_o_register, 10);
    tick();
    mid();
    check_eq("c1_elapsed_hold", data_o_register, 10);
    tick();
    set_cmd(RESTART, 1);
    tick();
    set_cmd(NOP, 0);
    mid();
    check_eq("c1_restart", status_register, 0);

    // cores 0 and 2 share the read port
    tick();
    set_cmd(START, 0);
    cop_ready = 4'b0001;
    tick();
    set_cmd(START, 2);
    cop_ready = 4'b0100;
    tick();
    set_cmd(NOP, 0);
    cop_ready = '0;
    cop_mem_valid = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      mid();
      check_eq($sformatf("arb_grant%0d", k), cop_mem_ready, exp_g[k]);
      check_eq($sformatf("arb_addr%0d", k), mem_r_addr, exp_a[k]);
      check_eq($sformatf("arb_dv%0d", k), cop_mem_data_valid, exp_dv[k]);
      if (k > 0) check_eq($sformatf("arb_data%0d", k), cop_mem_data, exp_d[k]);
      tick();
    end
    cop_mem_valid = '0;
    mid();
    check_eq("arb_idle_grant", cop_mem_ready, 0);
    check_eq("arb_last_dv", cop_mem_data_valid, 4'b0100);
    check_eq("arb_last_data", cop_mem_data, 64'hC0DE00000000001E);
    check_eq("two_running", status_register, 32'h80000041);
    tick();
    mid();
    check_eq("arb_dv_clear", cop_mem_data_valid, 0);

    // abort with RESET command
    tick();
    set_cmd(RESET, 0);
    mid();
    check_eq("abort_cop_rst", cop_rst, 1);
    tick();
    set_cmd(ELAPSED, 0);
    mid();
    check_eq("abort_status", status_register, 0);
    check_eq("abort_cnt0", data_o_register, 0);
    check_eq("abort_rst_low", cop_rst, 0);

    // core 3: error beats done; write blocked while running
    tick();
    set_cmd(START, 3);
    cop_ready = 4'b1000;
    tick();
    cop_ready = '0;
    set_cmd(WRITE, 3);
    address_register = 7;
    data_in_register = 64'h77;
    mid();
    check_eq("c3_w_blocked", mem_w_valid, 0);
    check_eq("c3_running", status_register, 32'h80000200);
    tick();
    set_cmd(NOP, 3);
    cop_done = 4'b1000;
    cop_error = 4'b1000;
    cop_accept = 4'b1000;
    tick();
    cop_done = '0; cop_error = '0; cop_accept = '0;
    mid();
    check_eq("c3_error", status_register, 32'h00000800);
    tick();
    set_cmd(RESTART, 3);
    tick();
    set_cmd(START, 3);
    cop_ready = 4'b1000;
    tick();
    set_cmd(NOP, 3);
    cop_ready = '0;
    cop_done = 4'b1000;
    tick();
    cop_done = '0;
    mid();
    check_eq("c3_rejected", status_register, 32'h00000600);

    // idle core with cop_valid is eligible; idle core without it is not
    tick();
    set_cmd(START, 1);
    cop_mem_valid = 4'b0011;
    mid();
    check_eq("idle_grant", cop_mem_ready, 4'b0010);
    check_eq("idle_addr", mem_r_addr, 20);
    tick();
    cop_mem_valid = '0;
    set_cmd(NOP, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
